// File: rtl/ethernet_rx_fifo.sv
// rtl/ethernet_rx_fifo.sv - MII receive framer feeding a commit/rollback byte FIFO
//
// Purpose: strips preamble/SFD from an MII receive stream, packs nibbles into
// bytes and stores them in a circular buffer. A frame only becomes visible to
// the reader when it ends cleanly. Bad frames are rolled back and counted.
//
// Ports:
//   clk                 single clock, rising edge
//   reset               synchronous, active-low
//   ethernet_rx_en      one-cycle strobe per MII nibble
//   ethernet_rx_dv      receive data valid, sampled every cycle
//   ethernet_rx_er      receive error, sampled on strobes
//   ethernet_rx         receive nibble, sampled on strobes
//   ethernet_rd         pop one committed byte
//   frame_rx            popped data byte
//   frame_last          popped byte is the last of its frame
//   ethernet_empty      no committed byte available
//   ethernet_full       write pointer one entry behind read pointer
//   drop_count          saturating count of discarded frames
module ethernet_rx_fifo #(
  parameter int ADDR_WIDTH = 11,
  parameter int MIN_FRAME  = 64,
  parameter int MAX_FRAME  = 1518,
  parameter int DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ethernet_rx_en,
  input  logic                  ethernet_rx_dv,
  input  logic                  ethernet_rx_er,
  input  logic [3:0]            ethernet_rx,
  input  logic                  ethernet_rd,
  output logic [7:0]            frame_rx,
  output logic                  frame_last,
  output logic                  ethernet_empty,
  output logic                  ethernet_full,
  output logic [DROP_WIDTH-1:0] drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // One spare code above MAX_FRAME so an over-length frame is representable.
  localparam int LEN_W = $clog2(MAX_FRAME + 2);

  localparam logic [LEN_W-1:0]      MIN_LEN  = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0]      MAX_LEN  = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0]      LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DROP_WIDTH-1:0] DROP_ONE = DROP_WIDTH'(1);
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [3:0]            low_q, low_d;
  logic [7:0]            held_q, held_d;
  logic                  held_valid_q, held_valid_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] cptr_q, cptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [7:0]            frame_rx_q, frame_rx_d;
  logic                  frame_last_q, frame_last_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;

  logic [8:0]            mem_q [DEPTH];
  logic                  wr_en;
  logic [8:0]            wr_data;
  logic                  drop_evt;

  // Empty compares against the commit pointer so uncommitted bytes stay hidden;
  // full compares the working pointer so a frame in flight cannot overrun.
  assign ethernet_empty = (rptr_q == cptr_q);
  assign ethernet_full  = ((wptr_q + PTR_ONE) == rptr_q);
  assign frame_rx       = frame_rx_q;
  assign frame_last     = frame_last_q;
  assign drop_count     = drop_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    low_d        = low_q;
    held_d       = held_q;
    held_valid_d = held_valid_q;
    len_d        = len_q;
    wptr_d       = wptr_q;
    cptr_d       = cptr_q;
    drop_d       = drop_q;
    wr_en        = 1'b0;
    wr_data      = 9'd0;
    drop_evt     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ethernet_rx_en && ethernet_rx_dv)
          state_d = (ethernet_rx == 4'h5) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!ethernet_rx_dv) begin
          state_d = IDLE;
        end else if (ethernet_rx_en) begin
          if (ethernet_rx == 4'hD) begin
            state_d      = DATA;
            phase_d      = 1'b0;
            len_d        = '0;
            held_valid_d = 1'b0;
            wptr_d       = cptr_q;
          end else if (ethernet_rx != 4'h5) begin
            state_d = DROP;
          end
        end
      end
      DATA: begin
        if (!ethernet_rx_dv) begin
          // End of frame: the held byte is the final one and carries the last flag.
          if (phase_q || (len_q < MIN_LEN) || ethernet_full) begin
            drop_evt = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_data = {1'b1, held_q};
            wptr_d  = wptr_q + PTR_ONE;
            cptr_d  = wptr_q + PTR_ONE;
          end
          state_d = IDLE;
        end else if (ethernet_rx_en) begin
          if (ethernet_rx_er) begin
            drop_evt = 1'b1;
          end else if (!phase_q) begin
            low_d   = ethernet_rx;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            len_d   = len_q + LEN_ONE;
            if (len_q >= MAX_LEN) begin
              drop_evt = 1'b1;
            end else if (held_valid_q && ethernet_full) begin
              drop_evt = 1'b1;
            end else begin
              // The previous byte is known not to be last now, so it can be stored.
              if (held_valid_q) begin
                wr_en   = 1'b1;
                wr_data = {1'b0, held_q};
                wptr_d  = wptr_q + PTR_ONE;
              end
              held_d       = {ethernet_rx, low_q};
              held_valid_d = 1'b1;
            end
          end
          if (drop_evt)
            state_d = DROP;
        end
      end
      DROP: begin
        if (!ethernet_rx_dv)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (drop_evt) begin
      wptr_d = cptr_q;
      if (drop_q != DROP_MAX)
        drop_d = drop_q + DROP_ONE;
    end
  end

  always_comb begin
    rptr_d       = rptr_q;
    frame_rx_d   = frame_rx_q;
    frame_last_d = frame_last_q;
    if (ethernet_rd && !ethernet_empty) begin
      {frame_last_d, frame_rx_d} = mem_q[rptr_q];
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      low_q        <= 4'd0;
      held_q       <= 8'd0;
      held_valid_q <= 1'b0;
      len_q        <= '0;
      wptr_q       <= '0;
      cptr_q       <= '0;
      rptr_q       <= '0;
      frame_rx_q   <= 8'd0;
      frame_last_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      low_q        <= low_d;
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      len_q        <= len_d;
      wptr_q       <= wptr_d;
      cptr_q       <= cptr_d;
      rptr_q       <= rptr_d;
      frame_rx_q   <= frame_rx_d;
      frame_last_q <= frame_last_d;
      drop_q       <= drop_d;
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (reset && wr_en)
      mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_ethernet_rx_fifo.sv
// tb/tb_ethernet_rx_fifo.sv - randomized self-checking bench for ethernet_rx_fifo
module tb_ethernet_rx_fifo;

  localparam int MIN0 = 64, MAX0 = 1518, DEP0 = 2048;
  localparam int MIN1 = 16, MAX1 = 60,   DEP1 = 64, DW1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [1:0]     mii_en, mii_dv, mii_er, rd;
  logic [3:0]     mii_rx [2];
  logic [7:0]     frame_rx_o [2];
  logic [1:0]     last_o, empty_o, full_o;
  logic [15:0]    drop0;
  logic [DW1-1:0] drop1;

  ethernet_rx_fifo u_dut0 (
    .clk(clk), .reset(reset),
    .ethernet_rx_en(mii_en[0]), .ethernet_rx_dv(mii_dv[0]),
    .ethernet_rx_er(mii_er[0]), .ethernet_rx(mii_rx[0]),
    .ethernet_rd(rd[0]), .frame_rx(frame_rx_o[0]), .frame_last(last_o[0]),
    .ethernet_empty(empty_o[0]), .ethernet_full(full_o[0]), .drop_count(drop0)
  );

  ethernet_rx_fifo #(
    .ADDR_WIDTH(6), .MIN_FRAME(MIN1), .MAX_FRAME(MAX1), .DROP_WIDTH(DW1)
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .ethernet_rx_en(mii_en[1]), .ethernet_rx_dv(mii_dv[1]),
    .ethernet_rx_er(mii_er[1]), .ethernet_rx(mii_rx[1]),
    .ethernet_rd(rd[1]), .frame_rx(frame_rx_o[1]), .frame_last(last_o[1]),
    .ethernet_empty(empty_o[1]), .ethernet_full(full_o[1]), .drop_count(drop1)
  );

  int           n_checks = 0;
  int           n_errors = 0;
  logic [8:0]   mq0 [$];
  logic [8:0]   mq1 [$];
  int           drops [2];
  logic [8:0]   last_rd [2];
  byte unsigned fbuf [1600];
  bit           ilv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction
  function automatic int depth(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction
  function automatic int minf(input int d);
    return (d == 0) ? MIN0 : MIN1;
  endfunction
  function automatic int maxf(input int d);
    return (d == 0) ? MAX0 : MAX1;
  endfunction
  function automatic int exp_drop(input int d);
    int sat;
    sat = (d == 0) ? 65535 : (1 << DW1) - 1;
    return (drops[d] > sat) ? sat : drops[d];
  endfunction
  function automatic int got_drop(input int d);
    return (d == 0) ? int'(drop0) : int'(drop1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int d);
    logic [8:0] e;
    check_eq($sformatf("rd_avail%0d", d), 32'(empty_o[d]), 32'(0));
    if (d == 0) e = mq0.pop_front();
    else        e = mq1.pop_front();
    last_rd[d] = e;
    rd[d] = 1'b1;
    tick();
    rd[d] = 1'b0;
    check_eq($sformatf("rd_data%0d", d), 32'(frame_rx_o[d]), 32'(e[7:0]));
    check_eq($sformatf("rd_last%0d", d), 32'(last_o[d]), 32'(e[8]));
  endtask

  task automatic empty_read(input int d);
    check_eq($sformatf("er_empty%0d", d), 32'(empty_o[d]), 32'(qsize(d) == 0));
    rd[d] = 1'b1;
    tick();
    rd[d] = 1'b0;
    check_eq($sformatf("er_hold_data%0d", d), 32'(frame_rx_o[d]), 32'(last_rd[d][7:0]));
    check_eq($sformatf("er_hold_last%0d", d), 32'(last_o[d]), 32'(last_rd[d][8]));
    check_eq($sformatf("er_still_empty%0d", d), 32'(empty_o[d]), 32'(1));
  endtask

  task automatic drain(input int d);
    while (qsize(d) > 0) do_read(d);
  endtask

  task automatic send_nibble(input int d, input logic [3:0] nib, input bit er);
    mii_rx[d] = nib;
    mii_er[d] = er;
    mii_en[d] = 1'b1;
    tick();
    mii_en[d] = 1'b0;
    mii_er[d] = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      if (ilv && d == 0 && mq0.size() > 0 && $urandom_range(0, 1) == 1) do_read(0);
      else tick();
    end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input bit er);
    send_nibble(d, b[3:0], er);
    send_nibble(d, b[7:4], 1'b0);
  endtask

  task automatic start_frame(input int d, input bit bad_pre);
    mii_dv[d] = 1'b1;
    tick();
    if (bad_pre) send_nibble(d, 4'hA, 1'b0);
    repeat (15) send_nibble(d, 4'h5, 1'b0);
    send_nibble(d, 4'hD, 1'b0);
  endtask

  task automatic send_frame(input int d, input int len, input int err_at,
                            input bit extra, input bit bad_pre);
    bit acc;
    start_frame(d, bad_pre);
    for (int i = 0; i < len; i++) send_byte(d, fbuf[i], (i == err_at));
    if (extra) send_nibble(d, 4'h3, 1'b0);
    check_eq($sformatf("pre_eof_empty%0d", d), 32'(empty_o[d]), 32'(qsize(d) == 0));
    mii_dv[d] = 1'b0;
    tick();
    acc = !bad_pre && err_at < 0 && !extra && len >= minf(d) && len <= maxf(d)
          && (qsize(d) + len <= depth(d) - 1);
    if (acc) begin
      for (int i = 0; i < len; i++) begin
        if (d == 0) mq0.push_back({(i == len - 1), fbuf[i]});
        else        mq1.push_back({(i == len - 1), fbuf[i]});
      end
    end else if (!bad_pre) begin
      drops[d]++;
    end
    check_eq($sformatf("eof_empty%0d", d), 32'(empty_o[d]), 32'(qsize(d) == 0));
    check_eq($sformatf("full%0d", d), 32'(full_o[d]), 32'(qsize(d) == depth(d) - 1));
    check_eq($sformatf("drops%0d", d), 32'(got_drop(d)), 32'(exp_drop(d)));
    tick();
  endtask

  task automatic fill_seq(input int len);
    for (int i = 0; i < len; i++) fbuf[i] = 8'(i);
  endtask

  task automatic fill_rand(input int len);
    for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_reset_vals(input int d);
    check_eq($sformatf("rst_data%0d", d), 32'(frame_rx_o[d]), 32'(0));
    check_eq($sformatf("rst_last%0d", d), 32'(last_o[d]), 32'(0));
    check_eq($sformatf("rst_empty%0d", d), 32'(empty_o[d]), 32'(1));
    check_eq($sformatf("rst_full%0d", d), 32'(full_o[d]), 32'(0));
    check_eq($sformatf("rst_drop%0d", d), 32'(got_drop(d)), 32'(0));
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    drops[0] = 0;
    drops[1] = 0;
    last_rd[0] = 9'd0;
    last_rd[1] = 9'd0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    mii_en = '0; mii_dv = '0; mii_er = '0; rd = '0;
    mii_rx[0] = 4'd0; mii_rx[1] = 4'd0;
    ilv = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset_vals(0);
    check_reset_vals(1);
    reset = 1'b1;
    tick();

    // Clean 64-byte frame, read back in order
    fill_seq(64);
    send_frame(0, 64, -1, 1'b0, 1'b0);
    drain(0);

    // Errored frame, then a good one
    send_frame(0, 64, 10, 1'b0, 1'b0);
    send_frame(0, 64, -1, 1'b0, 1'b0);
    drain(0);

    // Short frame and odd nibble count
    fill_seq(64);
    send_frame(0, 63, -1, 1'b0, 1'b0);
    send_frame(0, 64, -1, 1'b1, 1'b0);

    // Garbage before preamble is discarded without counting
    send_frame(0, 64, -1, 1'b0, 1'b1);
    empty_read(0);

    // Reads interleaved with reception, plus reads while empty
    fill_rand(64);
    send_frame(0, 64, -1, 1'b0, 1'b0);
    ilv = 1'b1;
    fill_rand(70);
    send_frame(0, 70, -1, 1'b0, 1'b0);
    ilv = 1'b0;
    drain(0);
    empty_read(0);

    // Small FIFO: second frame overflows, third fits after draining
    fill_rand(40);
    send_frame(1, 40, -1, 1'b0, 1'b0);
    fill_rand(40);
    send_frame(1, 40, -1, 1'b0, 1'b0);
    drain(1);
    fill_rand(40);
    send_frame(1, 40, -1, 1'b0, 1'b0);
    drain(1);
    empty_read(1);

    // Length boundaries and drop counter saturation on the small FIFO
    fill_rand(61);
    send_frame(1, MIN1, -1, 1'b0, 1'b0);
    drain(1);
    send_frame(1, MIN1 - 1, -1, 1'b0, 1'b0);
    send_frame(1, MAX1, -1, 1'b0, 1'b0);
    drain(1);
    send_frame(1, MAX1 + 1, -1, 1'b0, 1'b0);
    repeat (6) send_frame(1, 5, -1, 1'b0, 1'b0);

    // Random frames with random faults and random read bursts
    for (int f = 0; f < 12; f++) begin
      int len, mode;
      len  = $urandom_range(60, 80);
      mode = $urandom_range(0, 5);
      fill_rand(len);
      send_frame(0, len, (mode == 0) ? int'($urandom_range(0, len - 1)) : -1,
                 (mode == 1), (mode == 2));
      repeat ($urandom_range(0, qsize(0))) do_read(0);
    end
    drain(0);

    // Reset in the middle of a frame with committed data still unread
    fill_rand(64);
    fbuf[0] = 8'hA5;
    send_frame(0, 64, -1, 1'b0, 1'b0);
    do_read(0);
    start_frame(0, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(0, fbuf[i], 1'b0);
    reset = 1'b0;
    mii_dv = '0;
    tick();
    model_reset();
    check_reset_vals(0);
    check_reset_vals(1);
    reset = 1'b1;
    tick();
    fill_seq(64);
    send_frame(0, 64, -1, 1'b0, 1'b0);
    drain(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
